// File: rtl/ntt_pkg.sv
// Shared NTT definitions: AGU state encoding, default BRAM address width and
// the legal configuration ranges used by the AGU and the butterfly datapath.
// No logic, no latency, no flow control.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } ntt_state_t;

    localparam int ADDR_W_DEF = 15;

    // Legal transform sizes are 2^LOGN_MIN .. 2^LOGN_MAX; the read-to-write
    // latency must cover the registered BRAM read plus at least two
    // butterfly pipeline stages.
    localparam int LOGN_MIN = 2;
    localparam int LOGN_MAX = 15;
    localparam int LAT_MIN  = 3;

endpackage

// File: rtl/ntt_delay_line.sv
// DEPTH-deep shift register of {valid, address}; aligns write-back control
// with the read stream. Latency: exactly DEPTH cycles. No backpressure: it
// shifts every cycle. DEPTH must be >= 2.
// Ports: clk, rst_n (async active-low clear), vld_i/dat_i in, vld_o/dat_o out.
module ntt_delay_line #(
    parameter int DEPTH = 8,
    parameter int W     = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0][W-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], vld_i};
            dat_q <= {dat_q[DEPTH-2:0], dat_i};
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/ntt_bfly_agu.sv
// Butterfly address generator for an in-place radix-2 DIF NTT over one BRAM.
// Latency: first read 1 cycle after start is accepted; writes trail reads by LAT.
// No backpressure: streams run free; a LAT-cycle drain separates stages.
// Ports: clk, rst_n, start in; busy, done, rd_addr/rd_valid/rd_phase, tw_addr,
// wr_addr/wr_en out. All outputs are registered or decoded from state.
module ntt_bfly_agu
    import ntt_pkg::*;
#(
    parameter int LOGN   = 15,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LAT    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_phase,
    output logic [LOGN-2:0]   tw_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en
);

    localparam int JW = LOGN - 1;          // butterfly index width
    localparam int SW = $clog2(LOGN);      // stage index width
    localparam int CW = $clog2(LAT + 1);   // drain counter width
    localparam int TW = LOGN - 1;          // twiddle index width

    localparam logic [JW-1:0] J_LAST = {JW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

    ntt_state_t        state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [JW-1:0]     j_q, j_d;
    logic              ph_q, ph_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_phase_q, rd_phase_d;
    logic [TW-1:0]     tw_q, tw_d;
    logic              done_q, done_d;

    // Address math for the current (s, j): h = LOGN-1-s selects the split
    // bit, k is the offset inside the group, and the group index is shifted
    // up one place to open a zero at bit h for the partner offset.
    logic [SW-1:0]     h;
    logic [ADDR_W-1:0] j_ext, half, mask, k, a_addr;

    assign h      = S_LAST - s_q;
    assign j_ext  = ADDR_W'(j_q);
    assign half   = ADDR_W'(1) << h;
    assign mask   = half - ADDR_W'(1);
    assign k      = j_ext & mask;
    assign a_addr = (((j_ext >> h) << h) << 1) | k;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    j_d     = '0;
                    ph_d    = 1'b0;
                end
            end
            ST_RUN: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    j_d = j_q + 1'b1;
                    if (j_q == J_LAST) begin
                        cnt_d   = '0;
                        state_d = (s_q == S_LAST) ? ST_FIN : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // LAT idle read slots let the last write of this stage land
                // no later than the first read of the next one.
                if (cnt_q == CW'(LAT - 1)) begin
                    state_d = ST_RUN;
                    s_d     = s_q + 1'b1;
                    j_d     = '0;
                    ph_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIN: begin
                // One extra cycle past LAT so done follows the final write.
                if (cnt_q == CW'(LAT)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read stream is registered: the slot computed while in RUN appears on
    // the BRAM port one cycle later.
    always_comb begin
        rd_valid_d = (state_q == ST_RUN);
        rd_phase_d = 1'b0;
        rd_addr_d  = '0;
        tw_d       = '0;
        if (state_q == ST_RUN) begin
            rd_phase_d = ph_q;
            rd_addr_d  = ph_q ? (a_addr | half) : a_addr;
            tw_d       = TW'(k << s_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            j_q        <= '0;
            ph_q       <= 1'b0;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_phase_q <= 1'b0;
            tw_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            j_q        <= j_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            rd_phase_q <= rd_phase_d;
            tw_q       <= tw_d;
            done_q     <= done_d;
        end
    end

    ntt_delay_line #(
        .DEPTH (LAT),
        .W     (ADDR_W)
    ) u_wb_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (rd_valid_q),
        .dat_i (rd_addr_q),
        .vld_o (wr_en),
        .dat_o (wr_addr)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign rd_addr  = rd_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_phase = rd_phase_q;
    assign tw_addr  = tw_q;

endmodule

// File: tb/tb_ntt_bfly_agu.sv
// Bench for ntt_bfly_agu: scoreboard of expected read/write/done events built
// from the DIF butterfly schedule, a negedge monitor that pops and compares,
// and a BRAM stage tracker checking read-after-write ordering across stages.
module tb_ntt_bfly_agu;

    localparam int LA = 3, TA = 4, WA = 4, NA = 1 << LA;
    localparam int LB = 2, TB = 3, WB = 3, NB = 1 << LB;

    typedef struct { int cyc; int addr; int ph; int tw; } rd_exp_t;
    typedef struct { int cyc; int addr; } wr_exp_t;

    logic clk = 1'b0;
    logic rst_n, start, rst_nb, start_b;

    logic          busy_a, done_a, rd_valid_a, rd_phase_a, wr_en_a;
    logic [WA-1:0] rd_addr_a, wr_addr_a;
    logic [LA-2:0] tw_a;
    logic          busy_b, done_b, rd_valid_b, rd_phase_b, wr_en_b;
    logic [WB-1:0] rd_addr_b, wr_addr_b;
    logic [LB-2:0] tw_b;

    int cyc = 0;
    int ntests = 0;
    int nfail = 0;
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    int      done_q[$];
    int      run_start = 0;
    int      run_done = -1;

    ntt_bfly_agu #(.LOGN(LA), .ADDR_W(WA), .LAT(TA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a),
        .rd_addr(rd_addr_a), .rd_valid(rd_valid_a), .rd_phase(rd_phase_a),
        .tw_addr(tw_a), .wr_addr(wr_addr_a), .wr_en(wr_en_a)
    );

    ntt_bfly_agu #(.LOGN(LB), .ADDR_W(WB), .LAT(TB)) u_dut_b (
        .clk(clk), .rst_n(rst_nb), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .rd_phase(rd_phase_b),
        .tw_addr(tw_b), .wr_addr(wr_addr_b), .wr_en(wr_en_b)
    );

    always #5 clk = ~clk;

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference schedule: stage s splits the array into blocks of 2*span,
    // span = N/2^(s+1); each butterfly pairs blk+k with blk+k+span.
    task automatic accept_a(input int e);
        int t, span, idx;
        for (int s = 0; s < LA; s++) begin
            span = NA >> (s + 1);
            idx  = 0;
            for (int blk = 0; blk < NA; blk += 2 * span) begin
                for (int k = 0; k < span; k++) begin
                    t = e + s * (NA + TA) + 1 + 2 * idx;
                    rd_q.push_back('{t, blk + k, 0, k << s});
                    rd_q.push_back('{t + 1, blk + k + span, 1, k << s});
                    wr_q.push_back('{t + TA, blk + k});
                    wr_q.push_back('{t + 1 + TA, blk + k + span});
                    idx++;
                end
            end
        end
        run_start = e;
        run_done  = e + LA * (NA + TA) + 1;
        done_q.push_back(run_done);
    endtask

    // Drive start for one edge; the model accepts only when idle.
    task automatic step(input logic st);
        start = st;
        @(posedge clk);
        #2;
        start = 1'b0;
        if (st && cyc > run_done) accept_a(cyc);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy_a), 0);
        chk({tag, "_done"}, int'(done_a), 0);
        chk({tag, "_rd_valid"}, int'(rd_valid_a), 0);
        chk({tag, "_rd_phase"}, int'(rd_phase_a), 0);
        chk({tag, "_wr_en"}, int'(wr_en_a), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr_a), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr_a), 0);
        chk({tag, "_tw_addr"}, int'(tw_a), 0);
    endtask

    initial begin : monitor_a
        rd_exp_t re;
        wr_exp_t we;
        bit      exp_done;
        forever begin
            @(negedge clk);
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                chk("rd_late", cyc, rd_q[0].cyc);
                re = rd_q.pop_front();
            end
            if (rd_valid_a) begin
                if (rd_q.size() == 0 || rd_q[0].cyc != cyc) begin
                    chk("rd_valid_unexpected", int'(rd_valid_a), 0);
                end else begin
                    re = rd_q.pop_front();
                    chk("rd_addr", int'(rd_addr_a), re.addr);
                    chk("rd_phase", int'(rd_phase_a), re.ph);
                    if (re.ph == 0) chk("tw_addr", int'(tw_a), re.tw);
                end
            end
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                chk("wr_late", cyc, wr_q[0].cyc);
                we = wr_q.pop_front();
            end
            if (wr_en_a) begin
                if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
                    chk("wr_en_unexpected", int'(wr_en_a), 0);
                end else begin
                    we = wr_q.pop_front();
                    chk("wr_addr", int'(wr_addr_a), we.addr);
                end
            end
            exp_done = (done_q.size() > 0 && done_q[0] == cyc);
            if (exp_done) done_q.delete(0);
            chk("done", int'(done_a), int'(exp_done));
            chk("busy", int'(busy_a), int'(cyc >= run_start && cyc < run_done));
        end
    end

    // BRAM stage tracker: every read in stage s>0 must see the stage s-1 write.
    initial begin : hazard_a
        int wst[int];
        int nr, nw, ws;
        nr = 0;
        nw = 0;
        forever begin
            @(negedge clk);
            if (!busy_a) begin
                nr = 0;
                nw = 0;
                wst.delete();
            end
            if (wr_en_a) begin
                wst[int'(wr_addr_a)] = nw / NA;
                nw++;
            end
            if (rd_valid_a) begin
                if (nr / NA > 0) begin
                    ws = wst.exists(int'(rd_addr_a)) ? wst[int'(rd_addr_a)] : -1;
                    chk("hazard_a", ws, nr / NA - 1);
                end
                nr++;
            end
        end
    end

    initial begin : hazard_b
        int wst[int];
        int nr, nw, ws;
        nr = 0;
        nw = 0;
        forever begin
            @(negedge clk);
            if (!busy_b) begin
                nr = 0;
                nw = 0;
                wst.delete();
            end
            if (wr_en_b) begin
                wst[int'(wr_addr_b)] = nw / NB;
                nw++;
            end
            if (rd_valid_b) begin
                if (nr / NB > 0) begin
                    ws = wst.exists(int'(rd_addr_b)) ? wst[int'(rd_addr_b)] : -1;
                    chk("hazard_b", ws, nr / NB - 1);
                end
                nr++;
            end
        end
    end

    // Small config (LOGN=2, LAT=3): back-to-back runs, done timing.
    initial begin : stim_b
        int eb;
        rst_nb  = 1'b0;
        start_b = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_nb = 1'b1;
        for (int r = 0; r < 3; r++) begin
            start_b = 1'b1;
            @(posedge clk);
            #2;
            start_b = 1'b0;
            eb = cyc;
            chk("b_busy_start", int'(busy_b), 1);
            while (cyc < eb + LB * (NB + TB)) begin
                @(posedge clk);
                #2;
                chk("b_done_early", int'(done_b), 0);
            end
            @(posedge clk);
            #2;
            chk("b_done", int'(done_b), 1);
            chk("b_busy_end", int'(busy_b), 0);
        end
    end

    initial begin : stim_a
        int e0;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rst_n = 1'b1;
        step(1'b0);

        // Directed run with start pulses at relative cycles 5 and 20.
        step(1'b1);
        e0 = run_start;
        while (cyc < e0 + 4) step(1'b0);
        step(1'b1);
        while (cyc < e0 + 19) step(1'b0);
        step(1'b1);

        // Back-to-back: start raised in the done cycle.
        while (cyc < run_done) step(1'b0);
        step(1'b1);

        // Random gaps and random ignored start pulses.
        for (int r = 0; r < 6; r++) begin
            while (cyc < run_done) step(1'($urandom_range(0, 9) == 0));
            repeat ($urandom_range(0, 3)) step(1'b0);
            step(1'b1);
        end
        while (cyc < run_done) step(1'b0);
        step(1'b0);

        // Reset at relative cycle 10 of a fresh run.
        step(1'b1);
        e0 = run_start;
        while (cyc < e0 + 10) step(1'b0);
        rst_n = 1'b0;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        run_start = 0;
        run_done  = -1;
        #1;
        chk_zero("midrun_reset");
        repeat (TA + 3) step(1'b0);
        rst_n = 1'b1;
        step(1'b0);

        // Fresh start after reset must replay the full schedule.
        step(1'b1);
        while (cyc < run_done) step(1'b0);
        repeat (3) step(1'b0);

        chk("rd_queue_left", rd_q.size(), 0);
        chk("wr_queue_left", wr_q.size(), 0);
        chk("done_queue_left", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
